// File: rtl/pc_pkg.sv
// Shared types and constants for the program counter.
package pc_pkg;

  typedef logic [31:0] addr_t;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam addr_t PC_INC = 32'd4;

  // The JALR target is rs1 + imm with bit 0 cleared. No other alignment is applied.
  function automatic addr_t jalr_target(input addr_t rs1, input addr_t imm);
    addr_t sum;
    sum = rs1 + imm;
    return {sum[31:1], 1'b0};
  endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection: branch, JAL, JALR or sequential.
module pc_next_calc
  import pc_pkg::*;
(
  input  addr_t      pc,
  input  logic       branch,
  input  logic [6:0] opcode,
  input  addr_t      imm,
  input  addr_t      rs1,
  output addr_t      next_pc
);

  // Pick the target from the opcode. All sums wrap modulo 2^32.
  always_comb begin
    next_pc = pc + PC_INC;
    case (opcode)
      OPC_BRANCH: if (branch) next_pc = pc + imm;
      OPC_JAL:    next_pc = pc + imm;
      OPC_JALR:   next_pc = jalr_target(rs1, imm);
      default:    next_pc = pc + PC_INC;
    endcase
  end

endmodule

// File: rtl/program_counter.sv
// Program counter register with an asynchronous reset.
// An optional stall input is compiled in when PC_STALL_EN is defined.
module program_counter
  import pc_pkg::*;
#(
  parameter addr_t RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
`ifdef PC_STALL_EN
  input  logic        stall,
`endif
  input  logic        Branch,
  input  logic [6:0]  opcode,
  input  logic [31:0] Imm,
  input  logic [31:0] RS1_in,
  output logic [31:0] PC
);

  addr_t next_pc;
  logic  advance;

`ifdef PC_STALL_EN
  assign advance = ~stall;
`else
  assign advance = 1'b1;
`endif

  pc_next_calc u_next (
    .pc      (PC),
    .branch  (Branch),
    .opcode  (opcode),
    .imm     (Imm),
    .rs1     (RS1_in),
    .next_pc (next_pc)
  );

  // Reset wins over everything. Otherwise load the next PC unless stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        PC <= RESET_VECTOR;
    else if (advance) PC <= next_pc;
  end

endmodule

// File: tb/tb_program_counter.sv
// Scoreboard bench for program_counter. Stimulus pushes the expected PC for
// each step, and a negedge monitor pops and compares it.
// The stall checks are built only when PC_STALL_EN is defined.
module tb_program_counter;

  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        Branch = 1'b0;
  logic [6:0]  opcode = '0;
  logic [31:0] Imm = '0;
  logic [31:0] RS1_in = '0;
  logic [31:0] PC;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  program_counter #(.RESET_VECTOR(32'h0000_0000)) dut (
    .clk    (clk),
    .reset  (reset),
`ifdef PC_STALL_EN
    .stall  (stall),
`endif
    .Branch (Branch),
    .opcode (opcode),
    .Imm    (Imm),
    .RS1_in (RS1_in),
    .PC     (PC)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: PC=%h expected=%h", name, act, exp);
    end
  endfunction

  // Monitor: each negedge shows the PC that resulted from the step queued before it.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check(e.name, PC, e.exp);
    end
  end

  // Drive one instruction now and queue the PC expected after the next rising edge.
  task automatic step_now(input string name, input logic [6:0] op, input logic br,
                          input logic [31:0] imm, input logic [31:0] rs1,
                          input logic st, input logic [31:0] exp);
    exp_t e;
    opcode = op; Branch = br; Imm = imm; RS1_in = rs1; stall = st;
    e.name = name; e.exp = exp;
    exp_q.push_back(e);
  endtask

  task automatic step(input string name, input logic [6:0] op, input logic br,
                      input logic [31:0] imm, input logic [31:0] rs1,
                      input logic st, input logic [31:0] exp);
    @(negedge clk); #1;
    step_now(name, op, br, imm, rs1, st, exp);
  endtask

  initial begin
    #1 reset = 1'b1;
    #2 check("reset_state", PC, 32'h0);

    // Release the reset together with the first instruction, so that no idle edge intervenes.
    @(negedge clk); #1;
    reset = 1'b0;
    step_now("br_taken",    OP_BR,   1'b1, 32'd20, 32'd0, 1'b0, 32'd20);
    step("jal",             OP_JAL,  1'b0, 32'd40, 32'd0, 1'b0, 32'd60);
    step("jalr_bit0",       OP_JALR, 1'b0, 32'd60, 32'd15, 1'b0, 32'd74);
    step("other_op",        7'd0,    1'b1, 32'd60, 32'd0, 1'b0, 32'd78);
    step("set_pc8",         OP_JALR, 1'b0, 32'd0,  32'd8, 1'b0, 32'd8);
    step("br_not_taken",    OP_BR,   1'b0, 32'd100, 32'd0, 1'b0, 32'd12);
    step("set_pc16",        OP_JALR, 1'b0, 32'd0,  32'd16, 1'b0, 32'd16);
    step("br_negative",     OP_BR,   1'b1, 32'hFFFF_FFF0, 32'd0, 1'b0, 32'd0);
    step("set_pc_top",      OP_JALR, 1'b0, 32'd0, 32'hFFFF_FFFC, 1'b0, 32'hFFFF_FFFC);
    step("seq_wrap",        7'd0,    1'b0, 32'd0,  32'd0, 1'b0, 32'd0);
    step("jal_neg_br0",     OP_JAL,  1'b0, 32'hFFFF_FFF8, 32'd0, 1'b0, 32'hFFFF_FFF8);
    step("jalr_odd",        OP_JALR, 1'b1, 32'd0,  32'd3, 1'b0, 32'd2);
    step("br_misaligned",   OP_BR,   1'b1, 32'd5,  32'd0, 1'b0, 32'd7);
    step("rtype_br1",       7'b0110011, 1'b1, 32'd100, 32'd0, 1'b0, 32'd11);
    step("jalr_neg_imm",    OP_JALR, 1'b0, 32'hFFFF_FFFF, 32'd100, 1'b0, 32'd98);

    // Async reset in the middle of a clock phase, with no edge in between.
    @(negedge clk);
    @(posedge clk); #2;
    reset = 1'b1;
    #1 check("async_reset", PC, 32'h0);
    opcode = OP_JAL; Imm = 32'd40;
    @(posedge clk); #1 check("reset_hold", PC, 32'h0);

    @(negedge clk); #1;
    reset = 1'b0;
    step_now("first_after_reset", OP_JAL, 1'b0, 32'd40, 32'd0, 1'b0, 32'd40);

`ifdef PC_STALL_EN
    step("stall_hold",      OP_JAL,  1'b0, 32'd40, 32'd0, 1'b1, 32'd40);
    step("stall_release",   OP_JAL,  1'b0, 32'd40, 32'd0, 1'b0, 32'd80);
    @(negedge clk); #1;
    stall = 1'b1;
    reset = 1'b1;
    #1 check("reset_over_stall", PC, 32'h0);
    @(negedge clk); #1;
    stall = 1'b0;
`endif

    // Let the monitor consume whatever is still queued, within a bounded number of cycles.
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/program_counter.md
PROGRAM_COUNTER -- requirements
Module: program_counter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter RESET_VECTOR SHALL default to 32'h0000_0000 and set the PC value loaded on reset.
REQ-003 Port clk SHALL be an input, 1 bit wide: the rising-edge clock.
REQ-004 Port reset SHALL be an input, 1 bit wide: the asynchronous, active-high reset.
REQ-005 Port Branch SHALL be an input, 1 bit wide: the conditional-branch-taken flag from the comparator.
REQ-006 Port opcode SHALL be an input, 7 bits wide: the opcode of the current instruction.
REQ-007 Port Imm SHALL be an input, 32 bits wide: the sign-extended immediate, already in byte units.
REQ-008 Port RS1_in SHALL be an input, 32 bits wide: the rs1 register value.
REQ-009 Port PC SHALL be an output, 32 bits wide: the current program counter, driven directly from a register.

Function
REQ-010 PC SHALL update only on the rising edge of clk while reset is low.
REQ-011 If opcode is 7'b1100011 (BRANCH) and Branch is 1, next PC SHALL be PC + Imm.
REQ-012 If opcode is 7'b1100011 and Branch is 0, next PC SHALL be PC + 4.
REQ-013 If opcode is 7'b1101111 (JAL), next PC SHALL be PC + Imm, whatever the value of Branch.
REQ-014 If opcode is 7'b1100111 (JALR), next PC SHALL be (RS1_in + Imm) with bit 0 forced to 0 and all other 31 bits kept; Branch is ignored.
REQ-015 For any other opcode, next PC SHALL be PC + 4, and Branch SHALL be ignored.
REQ-016 All additions SHALL be 32-bit and wrap modulo 2^32; a negative Imm (two's complement) SHALL move PC backwards.
REQ-017 Latency SHALL be one cycle: the next PC is computed combinationally from current inputs and becomes visible after the next rising edge.
REQ-018 The block SHALL perform no alignment checks other than the JALR bit-0 clear; misaligned targets pass through unchanged.

Reset
REQ-019 When reset is asserted, PC SHALL immediately take RESET_VECTOR, without waiting for a clock edge.
REQ-020 PC SHALL hold RESET_VECTOR while reset is high, including when reset is asserted in mid-operation.
REQ-021 On the first rising edge after reset deasserts, the normal next-PC rules SHALL apply.

Configuration
REQ-022 The macro PC_STALL_EN SHALL, when defined, add an input port stall (1 bit, active-high).
REQ-023 With PC_STALL_EN defined, PC SHALL hold its value on any clock edge where stall is 1; reset SHALL take priority over stall.
REQ-024 Without PC_STALL_EN, the stall port SHALL NOT exist and PC SHALL update on every clock edge.

Structure
REQ-025 Package pc_pkg SHALL hold the opcode constants OPC_BRANCH, OPC_JAL and OPC_JALR, the constant PC_INC = 4, and the 32-bit address typedef.
REQ-026 The combinational next-PC selection SHALL be a sub-module named pc_next_calc; program_counter SHALL hold only the register, the reset logic and the stall logic.

Verification
REQ-027 Reset scenario: assert reset asynchronously between clock edges -> PC = 0 at once, with no clock edge needed.
REQ-028 Branch and jump sequence from PC = 0, one clock edge per step:
- BRANCH with Branch = 1, Imm = 20 -> PC = 20.
- JAL, Imm = 40 -> PC = 60.
- JALR, RS1_in = 15, Imm = 60 -> PC = 74 (75 with bit 0 cleared).
- opcode 0, Imm = 60, Branch = 1 -> PC = 78.
REQ-029 Branch not taken: BRANCH with Branch = 0, Imm = 100, PC = 8 -> PC = 12.
REQ-030 Negative offset and wrap:
- BRANCH taken, Imm = 32'hFFFF_FFF0, PC = 16 -> PC = 0.
- opcode 0 at PC = 32'hFFFF_FFFC -> PC = 0.
REQ-031 Stall (only with PC_STALL_EN defined): stall = 1 with JAL, Imm = 40 -> PC unchanged; assert reset while stall = 1 -> PC = 0.
